// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of writeback entries; head entry is visible combinationally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PTR_W'(1);
      if (pop_i)  head_q <= head_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/writeback_unit.sv
// Merges in-order pipeline results and buffered long-latency results onto the regfile write port.
// Define WB_BYPASS_EN to forward the current write to the decode read operands.
module writeback_unit
  import wb_pkg::*;
#(
  parameter  int unsigned EXT_DEPTH    = 2,
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W        = $clog2(EXT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic [REG_ADDR_W-1:0] ext_rd,
  input  logic [XLEN-1:0]       ext_data,
  output logic [CNT_W-1:0]      ext_pending,
  output logic [REG_ADDR_W-1:0] rd_address,
  output logic [XLEN-1:0]       rd_data,
  input  logic [REG_ADDR_W-1:0] rs1_address,
  input  logic [REG_ADDR_W-1:0] rs2_address,
  input  logic [XLEN-1:0]       rs1_regfile_data,
  input  logic [XLEN-1:0]       rs2_regfile_data,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t            push_entry;
  wb_entry_t            head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 force_drain;
  logic [STARVE_W-1:0]  starve_q;
  logic [STARVE_W-1:0]  starve_d;

  always_comb begin
    push_entry.rd   = ext_rd;
    push_entry.data = ext_data;
  end

  wb_fifo #(.DEPTH(EXT_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (ext_pending)
  );

  // Write-port arbitration: a starved FIFO head beats the pipeline, which beats an idle-slot drain.
  always_comb begin
    pipe_stall  = 1'b0;
    rd_address  = ZERO_REG;
    rd_data     = '0;
    fifo_pop    = 1'b0;
    ext_ready   = !reset && !fifo_full;
    fifo_push   = ext_ready && ext_valid && (ext_rd != ZERO_REG);
    force_drain = (starve_q == STARVE_W'(STARVE_LIMIT)) && !fifo_empty;
    if (!reset) begin
      if (force_drain) begin
        rd_address = head.rd;
        rd_data    = head.data;
        fifo_pop   = 1'b1;
        pipe_stall = 1'b1;
      end else if (pipe_valid && (pipe_rd != ZERO_REG)) begin
        rd_address = pipe_rd;
        rd_data    = pipe_data;
      end else if (!fifo_empty) begin
        rd_address = head.rd;
        rd_data    = head.data;
        fifo_pop   = 1'b1;
      end
    end
  end

  // Counts cycles the head has waited without a pop; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

`ifdef WB_BYPASS_EN
  // The regfile writes at the edge, so a same-cycle read must see the write data here.
  always_comb begin
    rs1_data = rs1_regfile_data;
    rs2_data = rs2_regfile_data;
    if ((rd_address != ZERO_REG) && (rs1_address == rd_address)) rs1_data = rd_data;
    if ((rd_address != ZERO_REG) && (rs2_address == rd_address)) rs2_data = rd_data;
  end
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_address, rs2_address};
  assign rs1_data = rs1_regfile_data;
  assign rs2_data = rs2_regfile_data;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage, directly upstream of the register file.
- Merges two result sources onto the single regfile write port:
  - the in-order pipeline result, one per cycle;
  - a long-latency unit (divider/load miss) using a valid/ready handshake and buffered in a small FIFO.
- Also provides write-to-read bypass, because the regfile writes on the clock edge and a same-cycle read returns the old value.

Parameters:
- EXT_DEPTH, 2, number of long-latency FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go unserviced before the pipeline is stalled to drain it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pipe_valid  in  1  pipeline result present.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- pipe_stall  out  1  pipeline must hold its result this cycle; the result is not consumed.
- ext_valid  in  1  long-latency result offered.
- ext_ready  out  1  FIFO can accept.
- ext_rd  in  5  long-latency destination.
- ext_data  in  32  long-latency result.
- ext_pending  out  $clog2(EXT_DEPTH)+1  FIFO occupancy.
- rd_address  out  5  regfile write address; 0 means no write.
- rd_data  out  32  regfile write data.
- rs1_address  in  5  decode read address 1.
- rs2_address  in  5  decode read address 2.
- rs1_regfile_data  in  32  raw regfile read data 1.
- rs2_regfile_data  in  32  raw regfile read data 2.
- rs1_data  out  32  bypassed operand 1.
- rs2_data  out  32  bypassed operand 2.

Behaviour:
- State:
  - FIFO of EXT_DEPTH entries {rd, data}, with head/tail pointers and count.
  - starve_cnt, saturating at STARVE_LIMIT.
- Reset (synchronous) clears count, pointers and starve_cnt. While reset is high: ext_ready=0, pipe_stall=0, rd_address=0, rd_data=0.
- Handshakes:
  - ext_ready = (count < EXT_DEPTH), from registered count only; no combinational path from ext_valid.
  - Push on ext_valid && ext_ready.
  - An ext result with ext_rd=0 is accepted but discarded (not stored).
- Write-port selection each cycle (combinational, priority order):
  1. force = (starve_cnt == STARVE_LIMIT) && count>0: write FIFO head, pop, pipe_stall=1.
  2. pipe_valid && pipe_rd!=0: write pipeline result, pipe_stall=0.
  3. count>0: write FIFO head, pop.
  4. Otherwise: rd_address=0, rd_data=0.
- pipe_valid with pipe_rd=0 is consumed without a write; the slot is free for the FIFO (case 3).
- starve_cnt:
  - cleared on a pop or when count==0;
  - else incremented when count>0 and no pop, saturating.
- Push and pop in the same cycle: count unchanged.
- Push into an empty FIFO is not written in that same cycle (no FIFO fall-through); earliest write is the next cycle.
- Worst-case ext latency: STARVE_LIMIT+1 cycles after reaching head.
- Ordering: issue logic guarantees no outstanding WAW between the two sources. This block does not check it.
- Bypass, combinational:
  - rsN_data = rd_data if rd_address!=0 && rsN_address==rd_address;
  - else rsN_regfile_data.
  - Address 0 is never bypassed.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: bypass muxes as above.
- Undefined: rsN_data = rsN_regfile_data directly; the hazard unit must stall instead.
- Write-port behaviour is identical in both builds.

Decomposition:
- Package wb_pkg: XLEN=32, REG_ADDR_W=5, ZERO_REG=5'd0, typedef wb_entry_t {rd, data}.
- One sub-module, wb_fifo:
  - parameterised depth;
  - push/pop/full/empty/count interface;
  - head entry visible combinationally.
- Selection, starvation counter and bypass stay in writeback_unit.

Test Plan:
- Reset then idle → rd_address=0, ext_ready=1, ext_pending=0, pipe_stall=0.
- pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF; rs1_address=5, rs1_regfile_data=0 → same cycle rd_address=5, rd_data=0xDEADBEEF, rs1_data=0xDEADBEEF (bypass build) or 0 (non-bypass build).
- Push ext {rd=7, 0x11} with pipe idle → written the cycle after push, ext_pending returns to 0.
- Continuous pipe writes to rd=3, ext push {rd=9, 0x22}, STARVE_LIMIT=4 → starve_cnt reaches 4 four cycles after the push; the following cycle has pipe_stall=1 and rd_address=9; pipe result rd=3 is written the cycle after.
- Continuous pipe writes, three ext pushes with EXT_DEPTH=2 → ext_ready drops after the second push; the third push completes only after the first forced drain.
- FIFO holding 2 entries, reset asserted for one cycle → ext_pending=0, no write of stale entries afterwards.
- ext_rd=0 push and pipe_rd=0 valid → no regfile write; rs1_address=0 never bypassed.
